alu_i_fsm: RTL and testbench

ALU_I_FSM -- requirements
Module: ALUiFSM

---
 rtl/alu_i_fsm_if.sv | 29 ++
 rtl/alu_i_fsm.sv | 84 ++++++++
 tb/tb_alu_i_fsm.sv | 136 +++++++++++++
 3 files changed

// File: rtl/alu_i_fsm_if.sv
// Control-bus bundle between the ALU-immediate sequencer and the datapath it steers.
// The sequencer drives every control line; only the instruction word flows into it.
interface alu_i_fsm_if;
  logic [15:0] instruction;
  logic        done;
  logic [4:0]  rx_out;
  logic        alu_in0;
  logic        alu_in1;
  logic        alu_out_latch;
  logic        alu_out_en;
  logic [4:0]  rx_in;
  logic        pc_inc;
  logic [15:0] param2_out;
  logic        alu_imm_out;

  // master: the sequencer that issues control strobes
  modport master (
    input  instruction,
    output done, rx_out, alu_in0, alu_in1, alu_out_latch, alu_out_en,
           rx_in, pc_inc, param2_out, alu_imm_out
  );

  // slave: the datapath/bench side that supplies the instruction and obeys the strobes
  modport slave (
    output instruction,
    input  done, rx_out, alu_in0, alu_in1, alu_out_latch, alu_out_en,
           rx_in, pc_inc, param2_out, alu_imm_out
  );
endinterface

// File: rtl/alu_i_fsm.sv
// Moore sequencer for a register-immediate ALU instruction: read Rx, load immediate,
// execute, write back to Rx, bump the PC, then park in DONE until reset.
module alu_i_fsm (
  input  logic           clk,
  input  logic           rst,
  alu_i_fsm_if.master    bus,
  output logic [2:0]     state
);

  localparam logic [2:0] FETCH = 3'd0;
  localparam logic [2:0] LOADA = 3'd1;
  localparam logic [2:0] LOADB = 3'd2;
  localparam logic [2:0] EXEC  = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;
  localparam logic [2:0] INC   = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;

  logic [2:0] state_q;
  logic [4:0] rx_q;
  logic [5:0] imm_q;

  // The opcode is irrelevant here: every ALU-immediate op runs the same sequence.
  logic unused_opcode;
  assign unused_opcode = ^bus.instruction[15:11];

  assign state = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      rx_q    <= 5'd0;
      imm_q   <= 6'd0;
    end else begin
      case (state_q)
        FETCH: begin
          rx_q    <= bus.instruction[10:6];
          imm_q   <= bus.instruction[5:0];
          state_q <= LOADA;
        end
        LOADA:   state_q <= LOADB;
        LOADB:   state_q <= EXEC;
        EXEC:    state_q <= WRITE;
        WRITE:   state_q <= INC;
        INC:     state_q <= DONE;
        DONE:    state_q <= DONE;
        default: state_q <= FETCH;
      endcase
    end
  end

  // Outputs depend only on the registered state and captured fields, never on the live instruction.
  always_comb begin
    bus.done          = 1'b0;
    bus.rx_out        = 5'd0;
    bus.alu_in0       = 1'b0;
    bus.alu_in1       = 1'b0;
    bus.alu_out_latch = 1'b0;
    bus.alu_out_en    = 1'b0;
    bus.rx_in         = 5'd0;
    bus.pc_inc        = 1'b0;
    bus.param2_out    = 16'd0;
    bus.alu_imm_out   = 1'b0;
    case (state_q)
      LOADA: begin
        bus.rx_out  = rx_q;
        bus.alu_in0 = 1'b1;
      end
      LOADB: begin
        bus.param2_out  = {10'd0, imm_q};
        bus.alu_imm_out = 1'b1;
        bus.alu_in1     = 1'b1;
      end
      EXEC:  bus.alu_out_latch = 1'b1;
      WRITE: begin
        bus.alu_out_en = 1'b1;
        bus.rx_in      = rx_q;
      end
      INC:   bus.pc_inc = 1'b1;
      DONE:  bus.done   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_i_fsm.sv
// Bench for alu_i_fsm: directed scenarios plus random instructions, mid-run instruction
// changes and asynchronous aborts, scored against a per-edge table of required outputs.
module tb_alu_i_fsm;

  localparam int W = 33;

  logic       clk;
  logic       rst;
  logic [2:0] state;

  alu_i_fsm_if bus ();

  alu_i_fsm dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.master),
    .state (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // {done, rx_out, alu_in0, alu_in1, alu_out_latch, alu_out_en, rx_in, pc_inc, param2_out, alu_imm_out}
  function automatic logic [W-1:0] pack(input logic d, input logic [4:0] ro, input logic i0,
                                        input logic i1, input logic lt, input logic en,
                                        input logic [4:0] ri, input logic pc,
                                        input logic [15:0] p2, input logic im);
    return {d, ro, i0, i1, lt, en, ri, pc, p2, im};
  endfunction

  function automatic logic [W-1:0] observed();
    return pack(bus.done, bus.rx_out, bus.alu_in0, bus.alu_in1, bus.alu_out_latch,
                bus.alu_out_en, bus.rx_in, bus.pc_inc, bus.param2_out, bus.alu_imm_out);
  endfunction

  function automatic logic [W-1:0] strobes_obs();
    return W'($countones({bus.alu_in0, bus.alu_in1, bus.alu_out_latch, bus.alu_out_en, bus.pc_inc}));
  endfunction

  // Required outputs k rising edges after release, for the instruction present at release.
  function automatic logic [W-1:0] model(input logic [15:0] instr, input int k);
    logic [4:0]  rx;
    logic [15:0] imm;
    rx  = instr[10:6];
    imm = {10'd0, instr[5:0]};
    if (k <= 0) return '0;
    case (k)
      1: return pack(1'b0, rx,   1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 16'd0, 1'b0);
      2: return pack(1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, imm,   1'b1);
      3: return pack(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 16'd0, 1'b0);
      4: return pack(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, rx,   1'b0, 16'd0, 1'b0);
      5: return pack(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 16'd0, 1'b0);
      default: return pack(1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 16'd0, 1'b0);
    endcase
  endfunction

  // ---------------- driver ----------------
  // Pulse reset, release on a falling edge, then score n_edges rising edges.
  // change_at > 0 rewrites the instruction just after that edge; abort_at > 0 pulls
  // rst low mid-cycle after that edge and checks the outputs clear without a clock.
  task automatic run_seq(input logic [15:0] instr, input int n_edges, input int change_at,
                         input logic [15:0] new_instr, input int abort_at);
    bus.instruction = instr;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_outputs", observed(), '0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("fetch_outputs", observed(), '0);
    exp_q.delete();
    for (int k = 1; k <= n_edges; k++) exp_q.push_back(model(instr, k));
    for (int k = 1; k <= n_edges; k++) begin
      logic [W-1:0] exp;
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      check($sformatf("edge%0d", k), observed(), exp);
      check($sformatf("strobes%0d", k), strobes_obs(), W'((k >= 1 && k <= 5) ? 1 : 0));
      if (k == change_at) bus.instruction = new_instr;
      if (k == abort_at) begin
        #2;
        rst = 1'b0;
        #1;
        check("async_abort", observed(), '0);
        return;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    bus.instruction = 16'h0000;
    #2;
    check("power_on_reset", observed(), '0);

    run_seq(16'h0044, 8, 0, 16'h0000, 0);          // ADD R1, 4
    run_seq(16'h07FF, 7, 0, 16'h0000, 0);          // Rx = 31, imm = 63
    run_seq(16'h0044, 8, 2, 16'hFFFF, 0);          // instruction changes after capture
    run_seq(16'h0044, 6, 0, 16'h0000, 3);          // abort during EXEC
    run_seq(16'h0044, 8, 0, 16'h0000, 0);          // full sequence again after abort
    run_seq(16'hF8C5, 26, 0, 16'h0000, 0);         // non-ADD opcode, 20 cycles past done

    for (int i = 0; i < 24; i++) begin
      logic [15:0] instr;
      logic [15:0] other;
      int chg;
      int abt;
      instr = 16'($urandom_range(0, 65535));
      other = 16'($urandom_range(0, 65535));
      chg   = $urandom_range(0, 6);
      abt   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      run_seq(instr, 6 + $urandom_range(1, 6), chg, other, abt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
